// File: rtl/team_06_echo_pkg.sv
// Shared types and sample-format constants for the team_06 multi-tap echo engine.
package team_06_echo_pkg;

  typedef enum logic [1:0] {
    ECHO_BYPASS   = 2'd0,
    ECHO_DELAY    = 2'd1,
    ECHO_FEEDBACK = 2'd2,
    ECHO_RSVD     = 2'd3
  } echo_mode_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_MIX     = 3'd3,
    S_WR_REQ  = 3'd4,
    S_WR_WAIT = 3'd5,
    S_OUT     = 3'd6
  } echo_state_e;

  // Offset-binary midpoint, i.e. the code for silence.
  function automatic int midpoint(input int unsigned w);
    return 1 << (w - 1);
  endfunction

  function automatic int sat_max(input int unsigned w);
    return midpoint(w) - 1;
  endfunction

  function automatic int sat_min(input int unsigned w);
    return -midpoint(w);
  endfunction

endpackage

// File: rtl/team_06_echo_if.sv
// History-SRAM request bus between the echo engine (master) and the memory controller (slave).
interface team_06_echo_if #(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned ADDR_W   = 13
);

  logic                mem_search;
  logic                mem_record;
  logic [ADDR_W-1:0]   mem_offset;
  logic [SAMPLE_W-1:0] mem_wdata;
  logic [SAMPLE_W-1:0] mem_rdata;
  logic                mem_done;

  modport master (
    output mem_search, mem_record, mem_offset, mem_wdata,
    input  mem_rdata, mem_done
  );

  modport slave (
    input  mem_search, mem_record, mem_offset, mem_wdata,
    output mem_rdata, mem_done
  );

endinterface

// File: rtl/team_06_echo_sat.sv
// Clamp a signed accumulator to OUT_W signed range and convert to offset-binary.
module team_06_echo_sat
  import team_06_echo_pkg::*;
#(
  parameter int unsigned IN_W  = 11,
  parameter int unsigned OUT_W = 8
) (
  input  logic signed [IN_W-1:0] din,
  output logic [OUT_W-1:0]       dout_c
);

  localparam logic signed [IN_W-1:0] MAX_S = IN_W'(sat_max(OUT_W));
  localparam logic signed [IN_W-1:0] MIN_S = IN_W'(sat_min(OUT_W));

  // In-range values: flipping the sign bit adds the midpoint.
  always_comb begin
    dout_c = {~din[OUT_W-1], din[OUT_W-2:0]};
    if (din > MAX_S) begin
      dout_c = '1;
    end else if (din < MIN_S) begin
      dout_c = '0;
    end
  end

endmodule

// File: rtl/team_06_echo_engine.sv
// Multi-tap echo/delay core: per tick reads NUM_TAPS history samples, mixes, records one sample.
// Optional build macro TEAM_06_ECHO_CLIPCNT_EN adds a saturating clip_count output.
module team_06_echo_engine
  import team_06_echo_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned NUM_TAPS = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_tick,
  input  logic [SAMPLE_W-1:0]          audio_in,
  input  logic [1:0]                   mode,
  input  logic [NUM_TAPS*ADDR_W-1:0]   tap_delay,
  input  logic [NUM_TAPS*3-1:0]        tap_shift,
  output logic [SAMPLE_W-1:0]          audio_out,
  output logic                         out_valid,
  team_06_echo_if.master               mem,
  output logic                         busy,
  output logic                         overrun,
  output logic                         err_timeout
`ifdef TEAM_06_ECHO_CLIPCNT_EN
  ,
  output logic [15:0]                  clip_count
`endif
);

  localparam int unsigned ACC_W = SAMPLE_W + 1 + $clog2(NUM_TAPS + 1);
  localparam int unsigned IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_TAPS - 1);
  localparam logic [SAMPLE_W-1:0] MID      = SAMPLE_W'(midpoint(SAMPLE_W));

  echo_state_e                 state_q, state_d;
  echo_mode_e                  mode_q, mode_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [SAMPLE_W-1:0]         dry_q, dry_d;
  logic [NUM_TAPS*ADDR_W-1:0]  delay_q, delay_d;
  logic [NUM_TAPS*3-1:0]       shift_q, shift_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic [SAMPLE_W-1:0]         wet_q, wet_d;
  logic [CNT_W-1:0]            wait_q, wait_d;
  logic [SAMPLE_W-1:0]         audio_out_q, audio_out_d;
  logic                        out_valid_q, out_valid_d;
  logic                        search_q, search_d;
  logic                        record_q, record_d;
  logic [ADDR_W-1:0]           offset_q, offset_d;
  logic [SAMPLE_W-1:0]         wdata_q, wdata_d;
  logic                        busy_q, busy_d;
  logic                        overrun_q, overrun_d;
  logic                        err_timeout_q, err_timeout_d;

  logic signed [SAMPLE_W-1:0]  dry_in_s;
  logic signed [SAMPLE_W-1:0]  rd_s;
  logic signed [SAMPLE_W-1:0]  rd_sh_s;
  logic signed [ACC_W-1:0]     contrib_s;
  logic [SAMPLE_W-1:0]         sat_c;
  logic                        timed_out_c;

`ifdef TEAM_06_ECHO_CLIPCNT_EN
  logic [15:0] clip_cnt_q, clip_cnt_d;
  logic        clip_c;
  // Accumulator fits the output range only if its top bits are pure sign extension.
  assign clip_c = ~((&acc_q[ACC_W-1:SAMPLE_W-1]) | ~(|acc_q[ACC_W-1:SAMPLE_W-1]));
  assign clip_count = clip_cnt_q;
`endif

  team_06_echo_sat #(
    .IN_W  (ACC_W),
    .OUT_W (SAMPLE_W)
  ) u_sat (
    .din    (acc_q),
    .dout_c (sat_c)
  );

  // Offset-binary to signed and per-tap attenuation of the returned history sample.
  always_comb begin
    dry_in_s    = $signed({~audio_in[SAMPLE_W-1], audio_in[SAMPLE_W-2:0]});
    rd_s        = $signed({~mem.mem_rdata[SAMPLE_W-1], mem.mem_rdata[SAMPLE_W-2:0]});
    rd_sh_s     = rd_s >>> shift_q[32'(idx_q) * 3 +: 3];
    contrib_s   = ACC_W'(rd_sh_s);
    timed_out_c = ~mem.mem_done & (wait_q == CNT_W'(TIMEOUT - 1));
  end

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    idx_d         = idx_q;
    dry_d         = dry_q;
    delay_d       = delay_q;
    shift_d       = shift_q;
    acc_d         = acc_q;
    wet_d         = wet_q;
    wait_d        = '0;
    audio_out_d   = audio_out_q;
    offset_d      = offset_q;
    wdata_d       = wdata_q;
    err_timeout_d = err_timeout_q;
    overrun_d     = overrun_q | (sample_tick & (state_q != S_IDLE));
`ifdef TEAM_06_ECHO_CLIPCNT_EN
    clip_cnt_d    = clip_cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (sample_tick) begin
          mode_d  = echo_mode_e'(mode);
          dry_d   = audio_in;
          delay_d = tap_delay;
          shift_d = tap_shift;
          idx_d   = '0;
          acc_d   = ACC_W'(dry_in_s);
          if (mode_d == ECHO_DELAY || mode_d == ECHO_FEEDBACK) begin
            state_d = S_RD_REQ;
          end else begin
            state_d = S_WR_REQ;
          end
        end
      end
      S_RD_REQ: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        wait_d = wait_q + CNT_W'(1);
        if (mem.mem_done || timed_out_c) begin
          if (mem.mem_done) begin
            acc_d = acc_q + contrib_s;
          end else begin
            err_timeout_d = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            state_d = S_MIX;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_RD_REQ;
          end
        end
      end
      S_MIX: begin
        wet_d   = sat_c;
        state_d = S_WR_REQ;
`ifdef TEAM_06_ECHO_CLIPCNT_EN
        if (clip_c && clip_cnt_q != 16'hFFFF) begin
          clip_cnt_d = clip_cnt_q + 16'd1;
        end
`endif
      end
      S_WR_REQ: state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        wait_d = wait_q + CNT_W'(1);
        if (mem.mem_done || timed_out_c) begin
          if (!mem.mem_done) begin
            err_timeout_d = 1'b1;
          end
          state_d = S_OUT;
        end
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Registered strobes are asserted for the cycle the FSM sits in the matching state.
    search_d    = (state_d == S_RD_REQ);
    record_d    = (state_d == S_WR_REQ);
    out_valid_d = (state_d == S_OUT);
    busy_d      = (state_d != S_IDLE);
    if (state_d == S_RD_REQ) begin
      offset_d = delay_d[32'(idx_d) * ADDR_W +: ADDR_W];
    end
    if (state_d == S_WR_REQ) begin
      offset_d = '0;
      wdata_d  = (mode_d == ECHO_FEEDBACK) ? wet_d : dry_d;
    end
    if (state_d == S_OUT) begin
      audio_out_d = (mode_q == ECHO_DELAY || mode_q == ECHO_FEEDBACK) ? wet_q : dry_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mode_q        <= ECHO_BYPASS;
      idx_q         <= '0;
      dry_q         <= '0;
      delay_q       <= '0;
      shift_q       <= '0;
      acc_q         <= '0;
      wet_q         <= '0;
      wait_q        <= '0;
      audio_out_q   <= MID;
      out_valid_q   <= 1'b0;
      search_q      <= 1'b0;
      record_q      <= 1'b0;
      offset_q      <= '0;
      wdata_q       <= '0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      err_timeout_q <= 1'b0;
`ifdef TEAM_06_ECHO_CLIPCNT_EN
      clip_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      idx_q         <= idx_d;
      dry_q         <= dry_d;
      delay_q       <= delay_d;
      shift_q       <= shift_d;
      acc_q         <= acc_d;
      wet_q         <= wet_d;
      wait_q        <= wait_d;
      audio_out_q   <= audio_out_d;
      out_valid_q   <= out_valid_d;
      search_q      <= search_d;
      record_q      <= record_d;
      offset_q      <= offset_d;
      wdata_q       <= wdata_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      err_timeout_q <= err_timeout_d;
`ifdef TEAM_06_ECHO_CLIPCNT_EN
      clip_cnt_q    <= clip_cnt_d;
`endif
    end
  end

  assign audio_out      = audio_out_q;
  assign out_valid      = out_valid_q;
  assign busy           = busy_q;
  assign overrun        = overrun_q;
  assign err_timeout    = err_timeout_q;
  assign mem.mem_search = search_q;
  assign mem.mem_record = record_q;
  assign mem.mem_offset = offset_q;
  assign mem.mem_wdata  = wdata_q;

endmodule

// File: tb/tb_team_06_echo_engine.sv
// Directed self-checking bench for team_06_echo_engine with a 1-cycle-latency history memory model.
module tb_team_06_echo_engine;
  import team_06_echo_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_tick;
  logic [7:0]  audio_in;
  logic [1:0]  mode;
  logic [25:0] tap_delay;
  logic [5:0]  tap_shift;
  logic [7:0]  audio_out;
  logic        out_valid;
  logic        busy;
  logic        overrun;
  logic        err_timeout;
`ifdef TEAM_06_ECHO_CLIPCNT_EN
  logic [15:0] clip_count;
`endif

  team_06_echo_if #(.SAMPLE_W(8), .ADDR_W(13)) mif ();

  team_06_echo_engine #(
    .SAMPLE_W (8),
    .ADDR_W   (13),
    .NUM_TAPS (2),
    .TIMEOUT  (255)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .audio_in    (audio_in),
    .mode        (mode),
    .tap_delay   (tap_delay),
    .tap_shift   (tap_shift),
    .audio_out   (audio_out),
    .out_valid   (out_valid),
    .mem         (mif),
    .busy        (busy),
    .overrun     (overrun),
    .err_timeout (err_timeout)
`ifdef TEAM_06_ECHO_CLIPCNT_EN
    ,
    .clip_count  (clip_count)
`endif
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_bad = 0;
  logic        hang = 1'b0;
  logic [7:0]  rd_val = 8'd128;
  int          n_search = 0;
  int          n_record = 0;
  int          n_valid = 0;
  logic [12:0] search_off [4];
  logic [7:0]  rec_wdata = '0;
  logic [12:0] rec_off = '0;
  int          lat;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Memory model acts at #1 after each edge; the bench acts at #2 so they never race.
  initial begin : mem_model
    logic req_seen;
    req_seen     = 1'b0;
    mif.mem_done  = 1'b0;
    mif.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mif.mem_done = 1'b0;
      if (req_seen && !hang) begin
        mif.mem_done  = 1'b1;
        mif.mem_rdata = rd_val;
      end
      req_seen = mif.mem_search | mif.mem_record;
      if (mif.mem_search) begin
        if (n_search < 4) search_off[n_search] = mif.mem_offset;
        n_search++;
      end
      if (mif.mem_record) begin
        n_record++;
        rec_wdata = mif.mem_wdata;
        rec_off   = mif.mem_offset;
      end
      if (out_valid) n_valid++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // One tick; lat counts cycles with the tick cycle as 1 and the out_valid cycle included.
  task automatic run_sample(input logic [1:0] m, input logic [7:0] a,
                            input logic [12:0] d0, input logic [12:0] d1,
                            input logic [2:0] s0, input logic [2:0] s1,
                            input logic [7:0] rd, output int l);
    n_search    = 0;
    n_record    = 0;
    n_valid     = 0;
    rd_val      = rd;
    mode        = m;
    audio_in    = a;
    tap_delay   = {d1, d0};
    tap_shift   = {s1, s0};
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    l = 2;
    while (!out_valid && l < 3000) begin
      cyc();
      l++;
    end
    check_eq("out_valid_arrives", 32'(out_valid), 32'd1);
    cyc();
  endtask

  initial begin
    rst         = 1'b1;
    sample_tick = 1'b0;
    audio_in    = '0;
    mode        = '0;
    tap_delay   = '0;
    tap_shift   = '0;
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_audio_out", 32'(audio_out), 32'd128);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_search", 32'(mif.mem_search), 32'd0);
    check_eq("rst_record", 32'(mif.mem_record), 32'd0);
    check_eq("rst_offset", 32'(mif.mem_offset), 32'd0);
    check_eq("rst_wdata", 32'(mif.mem_wdata), 32'd0);
    check_eq("rst_flags", {30'd0, overrun, err_timeout}, 32'd0);
    rst = 1'b0;
    cyc();

    // Bypass: dry passes through, one write, no reads
    run_sample(2'd0, 8'd200, 13'd0, 13'd0, 3'd0, 3'd0, 8'd0, lat);
    check_eq("byp_latency", 32'(lat), 32'd4);
    check_eq("byp_audio_out", 32'(audio_out), 32'd200);
    check_eq("byp_n_search", 32'(n_search), 32'd0);
    check_eq("byp_n_record", 32'(n_record), 32'd1);
    check_eq("byp_wdata", 32'(rec_wdata), 32'd200);
    check_eq("byp_n_valid", 32'(n_valid), 32'd1);

    // Reserved mode behaves as bypass
    run_sample(2'd3, 8'd55, 13'd7, 13'd9, 3'd0, 3'd0, 8'd0, lat);
    check_eq("rsvd_audio_out", 32'(audio_out), 32'd55);
    check_eq("rsvd_n_search", 32'(n_search), 32'd0);
    check_eq("rsvd_wdata", 32'(rec_wdata), 32'd55);

    // Delay: tap0 shift 1 gives +32, tap1 shift 7 rounds 64 to 0
    run_sample(2'd1, 8'd128, 13'd100, 13'd300, 3'd1, 3'd7, 8'd192, lat);
    check_eq("dly_latency", 32'(lat), 32'd9);
    check_eq("dly_audio_out", 32'(audio_out), 32'd160);
    check_eq("dly_n_search", 32'(n_search), 32'd2);
    check_eq("dly_off0", 32'(search_off[0]), 32'd100);
    check_eq("dly_off1", 32'(search_off[1]), 32'd300);
    check_eq("dly_wdata_dry", 32'(rec_wdata), 32'd128);
    check_eq("dly_wr_offset", 32'(rec_off), 32'd0);
    repeat (3) cyc();
    check_eq("dly_hold", 32'(audio_out), 32'd160);

    // Echo saturating high: 122 + 127 + 127 clamps to +127
    run_sample(2'd2, 8'd250, 13'd10, 13'd20, 3'd0, 3'd0, 8'd255, lat);
    check_eq("sat_hi_audio_out", 32'(audio_out), 32'd255);
    check_eq("sat_hi_wdata", 32'(rec_wdata), 32'd255);

    // Echo saturating low: -128 * 3 clamps to -128
    run_sample(2'd2, 8'd0, 13'd10, 13'd20, 3'd0, 3'd0, 8'd0, lat);
    check_eq("sat_lo_audio_out", 32'(audio_out), 32'd0);
    check_eq("sat_lo_wdata", 32'(rec_wdata), 32'd0);
`ifdef TEAM_06_ECHO_CLIPCNT_EN
    check_eq("clip_count_2", 32'(clip_count), 32'd2);
`endif

    // Echo in range: -28 + 16 + 8 = -4
    run_sample(2'd2, 8'd100, 13'd5, 13'd6, 3'd1, 3'd2, 8'd160, lat);
    check_eq("echo_audio_out", 32'(audio_out), 32'd124);
    check_eq("echo_wdata_wet", 32'(rec_wdata), 32'd124);
    check_eq("no_overrun_yet", 32'(overrun), 32'd0);
`ifdef TEAM_06_ECHO_CLIPCNT_EN
    check_eq("clip_count_hold", 32'(clip_count), 32'd2);
`endif

    // Overrun: second tick 2 cycles later is dropped
    n_valid     = 0;
    rd_val      = 8'd192;
    mode        = 2'd1;
    audio_in    = 8'd128;
    tap_delay   = {13'd300, 13'd100};
    tap_shift   = {3'd7, 3'd1};
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    audio_in    = 8'd10;
    cyc();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    repeat (20) cyc();
    check_eq("ovr_flag", 32'(overrun), 32'd1);
    check_eq("ovr_n_valid", 32'(n_valid), 32'd1);
    check_eq("ovr_audio_out", 32'(audio_out), 32'd160);
    check_eq("ovr_busy", 32'(busy), 32'd0);
    check_eq("no_timeout_yet", 32'(err_timeout), 32'd0);

    // Timeout: memory never answers, every request waits TIMEOUT cycles
    hang = 1'b1;
    run_sample(2'd1, 8'd77, 13'd100, 13'd300, 3'd0, 3'd0, 8'd255, lat);
    check_eq("to_flag", 32'(err_timeout), 32'd1);
    check_eq("to_audio_out", 32'(audio_out), 32'd77);
    check_eq("to_latency", 32'(lat), 32'd771);
    check_eq("to_busy", 32'(busy), 32'd0);

    // Asynchronous reset while waiting on a read
    mode        = 2'd1;
    audio_in    = 8'd90;
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    cyc();
    check_eq("rdw_busy", 32'(busy), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_audio_out", 32'(audio_out), 32'd128);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_flags", {30'd0, overrun, err_timeout}, 32'd0);
    cyc();
    rst  = 1'b0;
    hang = 1'b0;
    cyc();

    // Normal processing after reset: -68 + 32 + 0 = -36
    run_sample(2'd1, 8'd60, 13'd100, 13'd300, 3'd1, 3'd7, 8'd192, lat);
    check_eq("post_rst_audio_out", 32'(audio_out), 32'd92);
    check_eq("post_rst_latency", 32'(lat), 32'd9);
    check_eq("post_rst_n_valid", 32'(n_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
